// File: rtl/spi_slave.sv
// spi_slave: serial front end of the SPI-to-RAM subsystem.
// Deserialises 10-bit MOSI frames (MSB first) into rx_data with a one-cycle
// rx_valid strobe, and serialises 8-bit RAM read data back onto MISO after a
// read-data frame. A read-address frame must precede each read-data frame;
// rd_addr_seen remembers which of the two a "1x" command frame is.
// Optional feature: define SPI_SLAVE_MISO_OE_EN to add the miso_oe output,
// which is high exactly on the cycles MISO carries a read-data bit.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    output logic       miso_oe
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Progress within a frame once the command bit has been decoded:
    // shifting payload bits, waiting for RAM data, driving MISO, or finished.
    typedef enum logic [1:0] {
        PH_SHIFT,
        PH_WAIT_TX,
        PH_SEND,
        PH_DONE
    } phase_t;

    state_t     state;
    state_t     next_state;
    phase_t     phase;

    logic [3:0] bit_cnt;
    logic [8:0] shift_reg;
    logic       rd_addr_seen;
    logic [6:0] tx_shift;
    logic [2:0] tx_cnt;

    logic       in_frame;
    logic       frame_last;
    logic       load_tx;
    logic       send_bit;
    logic       send_end;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the command bit in CHK_CMD picks the frame type.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!SS_n) begin
                    next_state = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    next_state = IDLE;
                end else if (!MOSI) begin
                    next_state = WRITE;
                end else if (rd_addr_seen) begin
                    next_state = READ_DATA;
                end else begin
                    next_state = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Event strobes shared by the datapath blocks below.
    always_comb begin
        in_frame   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
        frame_last = !SS_n && in_frame && (phase == PH_SHIFT) && (bit_cnt == 4'd9);
        load_tx    = !SS_n && (state == READ_DATA) && (phase == PH_WAIT_TX) && tx_valid;
        send_bit   = !SS_n && (phase == PH_SEND) && (tx_cnt != 3'd0);
        send_end   = !SS_n && (phase == PH_SEND) && (tx_cnt == 3'd0);
    end

    // Frame phase tracking; SS_n high always rewinds to the shifting phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_SHIFT;
        end else if (SS_n) begin
            phase <= PH_SHIFT;
        end else if (frame_last) begin
            phase <= (state == READ_DATA) ? PH_WAIT_TX : PH_DONE;
        end else if (load_tx) begin
            phase <= PH_SEND;
        end else if (send_end) begin
            phase <= PH_DONE;
        end
    end

    // Bit counter and shift register collecting the first nine frame bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 4'd0;
            shift_reg <= 9'd0;
        end else if (SS_n) begin
            bit_cnt   <= 4'd0;
            shift_reg <= 9'd0;
        end else if (state == CHK_CMD) begin
            bit_cnt   <= 4'd1;
            shift_reg <= {shift_reg[7:0], MOSI};
        end else if (in_frame && (phase == PH_SHIFT)) begin
            bit_cnt   <= bit_cnt + 4'd1;
            shift_reg <= {shift_reg[7:0], MOSI};
        end
    end

    // Frame completion: publish the frame, pulse rx_valid, track read pairing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= 10'd0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (frame_last) begin
                rx_data  <= {shift_reg, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD) begin
                    rd_addr_seen <= 1'b1;
                end else if (state == READ_DATA) begin
                    rd_addr_seen <= 1'b0;
                end
            end
        end
    end

    // Readout: MSB goes out on the latching edge, the other seven follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MISO     <= 1'b0;
            tx_shift <= 7'd0;
            tx_cnt   <= 3'd0;
        end else if (SS_n) begin
            MISO     <= 1'b0;
            tx_shift <= 7'd0;
            tx_cnt   <= 3'd0;
        end else if (load_tx) begin
            MISO     <= tx_data[7];
            tx_shift <= tx_data[6:0];
            tx_cnt   <= 3'd7;
        end else if (send_bit) begin
            MISO     <= tx_shift[6];
            tx_shift <= {tx_shift[5:0], 1'b0};
            tx_cnt   <= tx_cnt - 3'd1;
        end else if (send_end) begin
            MISO     <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_MISO_OE_EN
    // Output enable follows exactly the cycles a data bit is on MISO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_oe <= 1'b0;
        end else begin
            miso_oe <= load_tx || send_bit;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized scoreboard bench for spi_slave.
// The driver tracks frame pairing with a simple "read address pending" bit
// and queues every expected rx_data frame and every expected MISO byte; a
// monitor process checks rx_valid/rx_data and MISO every cycle.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic       miso_oe;
`endif

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_SLAVE_MISO_OE_EN
        ,
        .miso_oe  (miso_oe)
`endif
    );

    int         check_count = 0;
    int         pass_count  = 0;

    logic [9:0] rx_q[$];
    logic [7:0] miso_q[$];
    bit         model_rd_pending = 1'b0;
    logic [9:0] model_last_rx    = 10'd0;
    bit         tx_accept        = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic noise_bit(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // One SS_n-low transaction. nbits < 10 aborts the frame after that many
    // frame bits; reset_at >= 0 pulses reset that many cycles into readout.
    task automatic apply_stimulus(input logic [9:0] frame, input int nbits,
                                  input int tx_delay, input logic [7:0] tx_byte,
                                  input int hold, input int noise, input int reset_at);
        bit is_read_data;
        bit reset_done;
        is_read_data = frame[9] && model_rd_pending;
        reset_done   = 1'b0;
        @(negedge clk);
        ss_n     = 1'b0;
        mosi     = 1'($urandom_range(0, 1));
        tx_valid = noise_bit(noise);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi     = frame[9-i];
            tx_valid = (is_read_data && i == 9) ? 1'b0 : noise_bit(noise);
        end
        if (nbits == 10) begin
            rx_q.push_back(frame);
            model_last_rx = frame;
            if (frame[9]) model_rd_pending = !model_rd_pending;
            if (is_read_data) begin
                for (int d = 0; d < tx_delay; d++) begin
                    @(negedge clk);
                    mosi     = 1'($urandom_range(0, 1));
                    tx_valid = 1'b0;
                end
                @(negedge clk);
                tx_valid  = 1'b1;
                tx_data   = tx_byte;
                tx_accept = 1'b1;
                miso_q.push_back(tx_byte);
                mosi      = 1'($urandom_range(0, 1));
                for (int j = 0; j < hold; j++) begin
                    @(negedge clk);
                    tx_accept = 1'b0;
                    if (j == reset_at) begin
                        rst_n    = 1'b0;
                        tx_valid = 1'b0;
                        #1;
                        check_output("miso_async_reset", miso, 0);
                        check_output("rx_valid_async_reset", rx_valid, 0);
                        check_output("rx_data_async_reset", rx_data, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
                        check_output("miso_oe_async_reset", miso_oe, 0);
`endif
                        model_rd_pending = 1'b0;
                        model_last_rx    = 10'd0;
                        reset_done       = 1'b1;
                        break;
                    end
                    tx_valid = noise_bit(noise);
                    tx_data  = 8'($urandom);
                    mosi     = 1'($urandom_range(0, 1));
                end
            end else begin
                for (int j = 0; j < hold; j++) begin
                    @(negedge clk);
                    mosi     = 1'($urandom_range(0, 1));
                    tx_valid = noise_bit(noise);
                end
            end
        end
        @(negedge clk);
        ss_n      = 1'b1;
        tx_valid  = 1'b0;
        tx_accept = 1'b0;
        mosi      = 1'b0;
        if (reset_done) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        repeat ($urandom_range(0, 1)) @(negedge clk);
        check_output("rx_data_hold", rx_data, model_last_rx);
    endtask

    // Monitor: pops expected frames on rx_valid and follows MISO bit by bit.
    initial begin : monitor
        bit         prev_valid;
        bit         active;
        logic [7:0] cur;
        int         pos;
        logic [9:0] exp_rx;
        logic       exp_miso;
        logic       exp_oe;
        prev_valid = 1'b0;
        active     = 1'b0;
        cur        = 8'd0;
        pos        = 0;
        forever begin
            @(posedge clk);
            #1;
            exp_miso = 1'b0;
            exp_oe   = 1'b0;
            if (!rst_n) begin
                active     = 1'b0;
                prev_valid = 1'b0;
                miso_q.delete();
            end else begin
                if (rx_valid) begin
                    check_output("rx_valid_back_to_back", prev_valid, 0);
                    if (rx_q.size() == 0) begin
                        check_output("rx_valid_unexpected", rx_valid, 0);
                    end else begin
                        exp_rx = rx_q.pop_front();
                        check_output("rx_data", rx_data, exp_rx);
                    end
                end
                prev_valid = rx_valid;
                if (ss_n) begin
                    active = 1'b0;
                end else if (tx_accept && miso_q.size() != 0) begin
                    cur      = miso_q.pop_front();
                    pos      = 7;
                    active   = 1'b1;
                    exp_miso = cur[7];
                    exp_oe   = 1'b1;
                end else if (active) begin
                    if (pos == 0) begin
                        active = 1'b0;
                    end else begin
                        pos      = pos - 1;
                        exp_miso = cur[pos];
                        exp_oe   = 1'b1;
                    end
                end
            end
            check_output("miso", miso, exp_miso);
`ifdef SPI_SLAVE_MISO_OE_EN
            check_output("miso_oe", miso_oe, exp_oe);
`else
            if (exp_oe === 1'bx) $display("[TB] unreachable");
`endif
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [9:0] frame;
        int         nbits;
        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_output("reset_miso", miso, 0);
        check_output("reset_rx_valid", rx_valid, 0);
        check_output("reset_rx_data", rx_data, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
        check_output("reset_miso_oe", miso_oe, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: write address, write data, read pair, abort, reset in readout.
        apply_stimulus(10'h0A5, 10, 0, 8'h00, 3, 1, -1);
        apply_stimulus(10'h13C, 10, 0, 8'h00, 2, 1, -1);
        apply_stimulus(10'h207, 10, 0, 8'h00, 2, 1, -1);
        apply_stimulus(10'h35A, 10, 3, 8'hC3, 10, 1, -1);
        apply_stimulus(10'h1FF, 6, 0, 8'h00, 0, 1, -1);
        apply_stimulus(10'h0F0, 10, 0, 8'h00, 1, 1, -1);
        apply_stimulus(10'h211, 10, 0, 8'h00, 0, 1, -1);
        apply_stimulus(10'h3AA, 10, 0, 8'h5E, 8, 1, 2);
        apply_stimulus(10'h2CC, 10, 0, 8'h00, 5, 2, -1);
        apply_stimulus(10'h399, 10, 0, 8'h81, 9, 0, -1);

        // Randomized traffic, including aborted frames and truncated readouts.
        for (int n = 0; n < 80; n++) begin
            frame = 10'($urandom);
            nbits = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 9)) : 10;
            if (frame[9] && model_rd_pending && nbits == 10) begin
                apply_stimulus(frame, nbits, int'($urandom_range(0, 4)), 8'($urandom),
                               int'($urandom_range(3, 11)), 1, -1);
            end else begin
                apply_stimulus(frame, nbits, 0, 8'h00, int'($urandom_range(0, 3)), 1, -1);
            end
        end

        repeat (5) @(negedge clk);
        check_output("rx_queue_drained", rx_q.size(), 0);
        check_output("miso_queue_drained", miso_q.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
